fetch_stage: RTL

//  IF stage plus IF/ID register of the pipelined MIPS core. Owns the PC and issues

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage_queue.sv | 83 ++++++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg : shared constants and types for the MIPS pipeline. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if : instruction-memory req/gnt/rvalid bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue : in-order FIFO of fetched words with flush. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  fetch_entry_t  din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (occ_q == CW'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full queue may take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      occ_d = occ_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_i && !pop_i && !flush_i) assert (!full_o);
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage : IF stage (PC, fetch credit, discard) plus IF/ID register. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 stall_d,
  output logic [31:0]          instr_d,
  output logic [5:0]           op_d,
  output logic [5:0]           funct_d,
  output logic [31:0]          pcplus4_d,
  output logic                 valid_d
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   instr_q, instr_d_n;
  logic [31:0]   pc4_q, pc4_d;
  logic          valid_q, valid_d_n;

  logic          req_w;
  logic          accept_w;
  logic          rsp_keep_w;
  logic          rsp_drop_w;
  logic          push_w;
  logic          pop_w;
  logic [CW:0]   inflight_w;
  logic [31:0]   target_w;
  logic          q_full_w;
  logic          q_empty_w;
  logic [CW-1:0] q_occ_w;
  fetch_entry_t  q_din_w;
  fetch_entry_t  q_dout_w;

  assign target_w   = redirect_pc & ~32'h3;
  assign inflight_w = {1'b0, q_occ_w} + {1'b0, outst_q};
  assign req_w      = ~reset & ~redirect & (disc_q == '0) &
                      (inflight_w < (CW+1)'(QDEPTH));
  assign accept_w   = req_w & imem.gnt;
  assign rsp_keep_w = imem.rvalid & (disc_q == '0);
  assign rsp_drop_w = imem.rvalid & (disc_q != '0);
  assign push_w     = rsp_keep_w & ~redirect;
  assign pop_w      = ~redirect & ~stall_d & ~q_empty_w;

  // Responses come back in issue order, so the PC of the next kept word is
  // simply a running counter restarted at every redirect.
  assign q_din_w.instr   = imem.rdata;
  assign q_din_w.pcplus4 = resp_pc_q + 32'd4;

  assign imem.req  = req_w;
  assign imem.addr = pc_q;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_w),
    .din_i   (q_din_w),
    .pop_i   (pop_w),
    .flush_i (redirect),
    .dout_o  (q_dout_w),
    .full_o  (q_full_w),
    .empty_o (q_empty_w),
    .occ_o   (q_occ_w)
  );

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    disc_d    = disc_q;
    instr_d_n = instr_q;
    pc4_d     = pc4_q;
    valid_d_n = valid_q;

    if (redirect) begin
      pc_d      = target_w;
      resp_pc_d = target_w;
      outst_d   = '0;
      // Everything still in flight becomes stale; a word arriving now counts.
      disc_d    = disc_q + outst_q - CW'(imem.rvalid);
      instr_d_n = NOP;
      valid_d_n = 1'b0;
    end else begin
      if (accept_w) pc_d = pc_q + 32'd4;
      if (push_w)   resp_pc_d = resp_pc_q + 32'd4;
      outst_d = outst_q + CW'(accept_w) - CW'(rsp_keep_w);
      disc_d  = disc_q - CW'(rsp_drop_w);
      if (!stall_d) begin
        if (!q_empty_w) begin
          instr_d_n = q_dout_w.instr;
          pc4_d     = q_dout_w.pcplus4;
          valid_d_n = 1'b1;
        end else begin
          instr_d_n = NOP;
          valid_d_n = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      disc_q    <= '0;
      instr_q   <= NOP;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      disc_q    <= disc_d;
      instr_q   <= instr_d_n;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d_n;
    end
  end

  assign instr_d   = instr_q;
  assign op_d      = instr_q[OP_MSB:OP_LSB];
  assign funct_d   = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pcplus4_d = pc4_q;
  assign valid_d   = valid_q;

  logic unused_w;
  assign unused_w = q_full_w;

endmodule

`default_nettype wire
